// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the program loader.
// The optional checksum stage is enabled with PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 8;
  localparam logic [7:0]  NOP_OP_DEF = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHK,
    S_RUN,
    S_ERR
  } ldr_state_t;
endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and CPU fetch port of the program loader.
interface prog_loader_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic [ADDR_W-1:0] PC;
  logic [DATA_W-1:0] INST;

  modport master (output din, din_valid, PC, input din_ready, INST);
  modport slave  (input din, din_valid, PC, output din_ready, INST);
endinterface

// File: rtl/prog_loader_inst_mem.sv
// Instruction memory: synchronous write, asynchronous read.
module inst_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed byte image into instruction memory, then serves INST for PC.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing two's-complement checksum byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned       DATA_W = DATA_W_DEF,
  parameter int unsigned       ADDR_W = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] NOP_OP = DATA_W'(NOP_OP_DEF)
) (
  input  logic          clk,
  input  logic          CLB,
  input  logic          load_start,
  prog_loader_if.slave  bus,
  output logic          cpu_clb,
  output logic          busy,
  output logic          err
);
  localparam int unsigned LEN_W = ADDR_W + 1;

  ldr_state_t        state, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  wr_addr, wr_addr_d;
  logic              accept;
  logic              we;
  logic [DATA_W-1:0] rdata;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum, sum_d;
`endif

  assign busy          = (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
  assign bus.din_ready = busy && !load_start;
  assign accept        = bus.din_valid && bus.din_ready;
  assign cpu_clb       = (state == S_RUN);
  assign err           = (state == S_ERR);
  assign we            = (state == S_DATA) && accept;

  always_ff @(posedge clk) begin
    if (!CLB) begin
      state   <= S_IDLE;
      len_q   <= '0;
      wr_addr <= '0;
    end else begin
      state   <= state_d;
      len_q   <= len_d;
      wr_addr <= wr_addr_d;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!CLB) sum <= '0;
    else      sum <= sum_d;
  end
`endif

  always_comb begin
    state_d   = state;
    len_d     = len_q;
    wr_addr_d = wr_addr;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d     = sum;
`endif
    if (load_start) begin
      state_d   = S_LEN;
      len_d     = '0;
      wr_addr_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_d     = '0;
`endif
    end else if (accept) begin
      case (state)
        S_LEN: begin
          // A zero length byte encodes a full 2**ADDR_W image.
          len_d   = (bus.din == '0) ? LEN_W'(2**ADDR_W) : LEN_W'(bus.din);
          state_d = S_DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d   = bus.din;
`endif
        end
        S_DATA: begin
          wr_addr_d = wr_addr + LEN_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d     = sum + bus.din;
          if (wr_addr + LEN_W'(1) == len_q) state_d = S_CHK;
`else
          if (wr_addr + LEN_W'(1) == len_q) state_d = S_RUN;
`endif
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHK: begin
          // Valid when checksum plus running sum wraps to zero.
          state_d = (DATA_W'(bus.din + sum) == '0) ? S_RUN : S_ERR;
        end
`endif
        default: state_d = state;
      endcase
    end
  end

  inst_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_addr[ADDR_W-1:0]),
    .wdata (bus.din),
    .raddr (bus.PC),
    .rdata (rdata)
  );

  assign bus.INST = ((state == S_RUN) && ({1'b0, bus.PC} < len_q)) ? rdata : NOP_OP;
endmodule

// File: tb/tb_prog_loader.sv
// Directed, table-driven bench for prog_loader (handles PROG_LOADER_CHECKSUM_EN builds too).
module tb_prog_loader;
  logic clk = 1'b0;
  logic CLB;
  logic load_start;
  logic cpu_clb, busy, err;

  prog_loader_if #(.DATA_W(8), .ADDR_W(8)) pif ();

  prog_loader #(
    .DATA_W (8),
    .ADDR_W (8),
    .NOP_OP (8'h00)
  ) dut (
    .clk        (clk),
    .CLB        (CLB),
    .load_start (load_start),
    .bus        (pif),
    .cpu_clb    (cpu_clb),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pc;
    logic [7:0] inst;
  } vec_t;

  vec_t       tv [8];
  int         ntv;
  logic [7:0] img [$];
  int         total = 0;
  int         bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_chk();
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] s;
    s = 8'h00;
    foreach (img[i]) s = s + img[i];
    img.push_back(~s + 8'h01);
`endif
  endtask

  task automatic load(input bit gapped, input bit expect_run);
    load_start    = 1'b1;
    pif.din_valid = 1'b1;
    pif.din       = 8'hEE;
    #1;
    check("start_ready", pif.din_ready, 1'b0);
    tick();
    load_start = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_clb", cpu_clb, 1'b0);
    for (int i = 0; i < img.size(); i++) begin
      pif.din       = img[i];
      pif.din_valid = 1'b1;
      #1;
      check("byte_ready", pif.din_ready, 1'b1);
      if (i == img.size() - 1) check("pre_final_clb", cpu_clb, 1'b0);
      tick();
      if (gapped && i != img.size() - 1) begin
        pif.din_valid = 1'b0;
        pif.din       = 8'h99;
        tick();
        check("gap_hold_busy", busy, 1'b1);
        check("gap_hold_clb", cpu_clb, 1'b0);
      end
    end
    pif.din_valid = 1'b0;
    check("final_clb", cpu_clb, expect_run);
    check("final_busy", busy, 1'b0);
    check("final_err", err, 1'b0 ^ (!expect_run));
  endtask

  task automatic run_table();
    for (int i = 0; i < ntv; i++) begin
      pif.PC = tv[i].pc;
      #1;
      check($sformatf("inst_pc%02h", tv[i].pc), pif.INST, tv[i].inst);
    end
  endtask

  initial begin
    CLB           = 1'b0;
    load_start    = 1'b0;
    pif.din       = 8'h00;
    pif.din_valid = 1'b1;
    pif.PC        = 8'h05;

    // Reset
    tick();
    tick();
    check("rst_inst", pif.INST, 8'h00);
    check("rst_clb", cpu_clb, 1'b0);
    check("rst_ready", pif.din_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    CLB           = 1'b1;
    pif.din_valid = 1'b0;
    tick();
    check("idle_busy", busy, 1'b0);

    // Basic load, back-to-back bytes
    img = '{8'h03, 8'hA1, 8'hB2, 8'hC3};
    add_chk();
    load(1'b0, 1'b1);
    tv[0] = '{8'h00, 8'hA1};
    tv[1] = '{8'h01, 8'hB2};
    tv[2] = '{8'h02, 8'hC3};
    tv[3] = '{8'h03, 8'h00};
    tv[4] = '{8'hFF, 8'h00};
    ntv = 5;
    run_table();

    // Overwrite with a different image, then gapped reload of the original
    img = '{8'h02, 8'h5A, 8'h5B};
    add_chk();
    load(1'b0, 1'b1);
    pif.PC = 8'h00;
    #1;
    check("mid_inst", pif.INST, 8'h5A);
    img = '{8'h03, 8'hA1, 8'hB2, 8'hC3};
    add_chk();
    load(1'b1, 1'b1);
    run_table();

    // Full 256-byte image
    img = '{8'h00};
    for (int i = 0; i < 256; i++) img.push_back(8'(i) ^ 8'h5A);
    add_chk();
    load(1'b0, 1'b1);
    tv[0] = '{8'hFF, 8'hA5};
    tv[1] = '{8'h00, 8'h5A};
    tv[2] = '{8'h80, 8'hDA};
    tv[3] = '{8'h7F, 8'h25};
    ntv = 4;
    run_table();

    // Restart mid-DATA
    load_start = 1'b1;
    tick();
    load_start    = 1'b0;
    pif.din_valid = 1'b1;
    pif.din       = 8'h03;
    tick();
    pif.din = 8'hA1;
    tick();
    pif.din    = 8'h55;
    load_start = 1'b1;
    #1;
    check("restart_ready", pif.din_ready, 1'b0);
    check("restart_busy", busy, 1'b1);
    tick();
    load_start = 1'b0;
    check("restart_len_busy", busy, 1'b1);
    check("restart_len_clb", cpu_clb, 1'b0);
    pif.din = 8'h01;
    tick();
    pif.din = 8'h77;
`ifdef PROG_LOADER_CHECKSUM_EN
    tick();
    pif.din = 8'h88;
`endif
    tick();
    pif.din_valid = 1'b0;
    check("restart_clb", cpu_clb, 1'b1);
    tv[0] = '{8'h00, 8'h77};
    tv[1] = '{8'h01, 8'h00};
    ntv = 2;
    run_table();

    // Reset in the middle of a load
    img = '{8'h05, 8'h11, 8'h22};
    load_start = 1'b1;
    tick();
    load_start    = 1'b0;
    pif.din_valid = 1'b1;
    foreach (img[i]) begin
      pif.din = img[i];
      tick();
    end
    CLB = 1'b0;
    tick();
    CLB           = 1'b1;
    pif.din_valid = 1'b0;
    pif.PC        = 8'h00;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_clb", cpu_clb, 1'b0);
    check("midrst_inst", pif.INST, 8'h00);
    check("midrst_ready", pif.din_ready, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Bad checksum lands in ERR; load_start clears it; good checksum runs
    img = '{8'h02, 8'h10, 8'h20, 8'h00};
    load(1'b0, 1'b0);
    pif.PC = 8'h00;
    #1;
    check("chk_bad_err", err, 1'b1);
    check("chk_bad_inst", pif.INST, 8'h00);
    check("chk_bad_ready", pif.din_ready, 1'b0);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("chk_clear_err", err, 1'b0);
    img = '{8'h02, 8'h10, 8'h20, 8'hCE};
    load(1'b0, 1'b1);
    tv[0] = '{8'h00, 8'h10};
    tv[1] = '{8'h01, 8'h20};
    tv[2] = '{8'h02, 8'h00};
    ntv = 3;
    run_table();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
